load_store_unit: RTL

Memory-access sequencer between the MEM-stage pipeline register and the word-wide data memory. Accepts one load/store request per handshake and checks alignment and funct3 legality. Issues word-aligned reads/writes, performs read-modify-write for byte/halfword stores because the memory only writes whole words, and returns sign/zero-extended load data. Multi-cycle; the pipeline stalls on `req_ready`.

---
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access sequencer between the MEM-stage pipeline
// register and a word-wide data memory. It accepts one load or store per
// handshake and rejects misaligned accesses and illegal funct3 values.
// Byte and halfword stores use read-modify-write because the memory only
// writes whole words. Load data is returned sign- or zero-extended.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_MERGE,
        S_LOAD_DATA,
        S_RESP
    } state_t;

    // funct3 encodings; bits [1:0] give the access size, bit 2 means unsigned
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t state, state_next;

    // Latched request, captured on the accept edge
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  accept;
    logic                  req_legal;
    logic                  req_misaligned;
    logic                  req_error;
    logic [DATA_W-1:0]     load_ext;
    logic [DATA_W-1:0]     merged;
    logic [4:0]            byte_shift;

    assign accept     = req_valid && req_ready;
    assign byte_shift = {addr_q[1:0], 3'b000};

    // Classify the incoming request: funct3 legality and natural alignment
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end
        if (req_funct3[1:0] == SZ_HALF) begin
            req_misaligned = req_addr[0];
        end else if (req_funct3[1:0] == SZ_WORD) begin
            req_misaligned = (req_addr[1:0] != 2'b00);
        end
        req_error = !req_legal || req_misaligned;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_error) begin
                        state_next = S_RESP;
                    end else if (req_we && (req_funct3[1:0] == SZ_WORD)) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ:      state_next = we_q ? S_MERGE : S_LOAD_DATA;
            S_WRITE:     state_next = S_RESP;
            S_MERGE:     state_next = S_RESP;
            S_LOAD_DATA: state_next = S_RESP;
            S_RESP:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Capture the request fields on the accept edge; ignored outside IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        byte_lane = mem_rdata[byte_shift +: 8];
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_ext = {24'h000000, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_ext = {16'h0000, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Replace the addressed byte/halfword lane of the read word with store data
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == SZ_BYTE) begin
            merged[byte_shift +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Memory strobes, address and write data decoded from state
    always_comb begin
        mem_re    = (state == S_READ);
        mem_we    = (state == S_WRITE) || (state == S_MERGE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_re || mem_we) begin
            mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
        end
        if (state == S_WRITE) begin
            mem_wdata = wdata_q;
        end else if (state == S_MERGE) begin
            mem_wdata = merged;
        end
    end

    // Response registers: updated only on the edge that enters RESP, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && req_error) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                S_WRITE, S_MERGE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                S_LOAD_DATA: begin
                    resp_rdata <= load_ext;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

endmodule
